hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types for the hazard controller.
//   state_e  : control FSM states (ST_MDWAIT only when HAZARD_MULDIV_EN is defined)
//   FWD_*    : E-operand forwarding selects
//   CNT_W    : stall/kill counter width (holds values up to 3)
//   sat_dec  : decrement that sticks at zero
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  localparam int CNT_W = $clog2(4);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
`ifdef HAZARD_MULDIV_EN
    , ST_MDWAIT = 2'd3
`endif
  } state_e;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- pipeline <-> hazard controller bundle.
//   D stage : rs1_d, rs2_d, re1_d, re2_d
//   E stage : rs1_e, rs2_e, rd_e, we_e, is_load_e, redirect_e, md_start_e
//   M/W     : rd_m, we_m, rd_w, we_w; md_done from the multi-cycle unit
//   Outputs : stall_f, stall_d, bubble_e, kill_f, kill_d, fwd_a_sel, fwd_b_sel
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              re1_d, re2_d, we_e, we_m, we_w;
  logic              is_load_e, redirect_e, md_start_e, md_done;
  logic              stall_f, stall_d, bubble_e, kill_f, kill_d;
  logic [1:0]        fwd_a_sel, fwd_b_sel;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           re1_d, re2_d, we_e, we_m, we_w,
           is_load_e, redirect_e, md_start_e, md_done,
    input  stall_f, stall_d, bubble_e, kill_f, kill_d, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           re1_d, re2_d, we_e, we_m, we_w,
           is_load_e, redirect_e, md_start_e, md_done,
    output stall_f, stall_d, bubble_e, kill_f, kill_d, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel -- forwarding select for one E operand (combinational).
//   rs          : operand source index in E
//   rd_m, we_m  : M-stage destination / write enable
//   rd_w, we_w  : W-stage destination / write enable
//   sel         : FWD_M beats FWD_W beats FWD_RF; index 0 never forwards
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic              we_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              we_w,
  output logic [1:0]        sel
);
  always_comb begin
    sel = FWD_RF;
    if (we_m && rd_m == rs && rd_m != '0)      sel = FWD_M;
    else if (we_w && rd_w == rs && rd_w != '0) sel = FWD_W;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller: forwarding, load-use stall,
// redirect kill and (optionally) multi-cycle unit wait.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : hazard_ctrl_if.slave (pipeline indices/enables in, stall/kill/fwd out)
// Config macro: HAZARD_MULDIV_EN enables the MDWAIT state driven by
// md_start_e / md_done; without it those inputs are ignored.
// Control outputs are combinational from state and current inputs so a hazard
// stalls in the cycle it is seen; rst gates every output low.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int KILL_DEPTH     = 2,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  hazard_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] KILL_LD  = CNT_W'(KILL_DEPTH - 1);
  localparam logic [CNT_W-1:0] STALL_LD = CNT_W'(LOAD_STALL_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             stall, kill;
  logic [1:0]       sel_a, sel_b;

  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs(bus.rs1_e), .rd_m(bus.rd_m), .we_m(bus.we_m),
    .rd_w(bus.rd_w), .we_w(bus.we_w), .sel(sel_a)
  );

  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs(bus.rs2_e), .rd_m(bus.rd_m), .we_m(bus.we_m),
    .rd_w(bus.rd_w), .we_w(bus.we_w), .sel(sel_b)
  );

  assign load_use = bus.is_load_e && bus.we_e && bus.rd_e != '0 &&
                    ((bus.re1_d && bus.rs1_d == bus.rd_e) ||
                     (bus.re2_d && bus.rs2_d == bus.rd_e));

`ifndef HAZARD_MULDIV_EN
  logic unused_md;
  assign unused_md = bus.md_start_e | bus.md_done;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    kill    = 1'b0;
    if (bus.redirect_e) begin
      // Redirect wins over everything except reset; any stall in flight is dropped.
      kill = 1'b1;
      if (KILL_DEPTH > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = KILL_LD;
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_FLUSH: begin
          // D is being squashed, so a load-use hazard here is ignored.
          kill  = 1'b1;
          cnt_d = sat_dec(cnt_q);
          if (cnt_d == '0) state_d = ST_RUN;
        end
        ST_LSTALL: begin
          stall = 1'b1;
          cnt_d = sat_dec(cnt_q);
          if (cnt_d == '0) state_d = ST_RUN;
        end
`ifdef HAZARD_MULDIV_EN
        ST_MDWAIT: begin
          stall = 1'b1;
          if (bus.md_done) state_d = ST_RUN;
        end
`endif
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
`ifdef HAZARD_MULDIV_EN
          if (bus.md_start_e) begin
            stall   = 1'b1;
            state_d = ST_MDWAIT;
          end else
`endif
          if (load_use) begin
            stall = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = ST_LSTALL;
              cnt_d   = STALL_LD;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_f   = stall && !rst;
  assign bus.stall_d   = stall && !rst;
  assign bus.bubble_e  = stall && !rst;
  assign bus.kill_f    = kill && !rst;
  assign bus.kill_d    = kill && !rst;
  assign bus.fwd_a_sel = rst ? FWD_RF : sel_a;
  assign bus.fwd_b_sel = rst ? FWD_RF : sel_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int AW  = 5;
  localparam int KD  = 2;
  localparam int LSC = 2;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_W(AW)) bus ();

  hazard_ctrl #(.ADDR_W(AW), .KILL_DEPTH(KD), .LOAD_STALL_CYC(LSC)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: cycles of kill / stall still owed, plus md busy flag.
  int m_kill_left  = 0;
  int m_stall_left = 0;
  bit m_md         = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (rst) return 2'd0;
    if (bus.we_m && bus.rd_m == rs && rs != 0) return 2'd1;
    if (bus.we_w && bus.rd_w == rs && rs != 0) return 2'd2;
    return 2'd0;
  endfunction

  task automatic clear_in();
    rst = 0;
    bus.rs1_d = 0; bus.rs2_d = 0; bus.rs1_e = 0; bus.rs2_e = 0;
    bus.rd_e = 0; bus.rd_m = 0; bus.rd_w = 0;
    bus.re1_d = 0; bus.re2_d = 0; bus.we_e = 0; bus.we_m = 0; bus.we_w = 0;
    bus.is_load_e = 0; bus.redirect_e = 0; bus.md_start_e = 0; bus.md_done = 0;
  endtask

  // Called at posedge+1 with inputs applied: check outputs, advance model, move
  // to the next posedge+1.
  task automatic step();
    bit lu, e_stall, e_kill;
    #3;
    lu = bus.is_load_e && bus.we_e && bus.rd_e != 0 &&
         ((bus.re1_d && bus.rs1_d == bus.rd_e) || (bus.re2_d && bus.rs2_d == bus.rd_e));
    e_stall = 0; e_kill = 0;
    if (rst) begin
      m_kill_left = 0; m_stall_left = 0; m_md = 0;
    end else if (bus.redirect_e) begin
      e_kill = 1; m_kill_left = KD - 1; m_stall_left = 0; m_md = 0;
    end else if (m_kill_left > 0) begin
      e_kill = 1; m_kill_left--;
    end else if (m_md) begin
      e_stall = 1; if (bus.md_done) m_md = 0;
    end else if (m_stall_left > 0) begin
      e_stall = 1; m_stall_left--;
    end else if (MD_EN && bus.md_start_e) begin
      e_stall = 1; m_md = 1;
    end else if (lu) begin
      e_stall = 1; m_stall_left = LSC - 1;
    end
    chk("stall_f",  8'(bus.stall_f),   8'(e_stall));
    chk("stall_d",  8'(bus.stall_d),   8'(e_stall));
    chk("bubble_e", 8'(bus.bubble_e),  8'(e_stall));
    chk("kill_f",   8'(bus.kill_f),    8'(e_kill));
    chk("kill_d",   8'(bus.kill_d),    8'(e_kill));
    chk("fwd_a",    8'(bus.fwd_a_sel), 8'(fwd_ref(bus.rs1_e)));
    chk("fwd_b",    8'(bus.fwd_b_sel), 8'(fwd_ref(bus.rs2_e)));
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    bus.is_load_e = 1; bus.we_e = 1; bus.rd_e = 7; bus.rs1_d = 7; bus.re1_d = 1;
  endtask

  initial begin
    clear_in();
    @(posedge clk);
    #1;

    // Reset with hazard-provoking inputs: everything must stay quiet.
    rst = 1; set_load_use(); bus.redirect_e = 1;
    bus.we_m = 1; bus.rd_m = 3; bus.rs1_e = 3;
    #2 chk("rst_fwd_a", 8'(bus.fwd_a_sel), 8'd0);
    chk("rst_kill", 8'(bus.kill_f), 8'd0);
    step();
    step();

    // M beats W, then W alone.
    clear_in();
    bus.we_m = 1; bus.rd_m = 5; bus.we_w = 1; bus.rd_w = 5; bus.rs1_e = 5;
    #2 chk("fwd_m_pri", 8'(bus.fwd_a_sel), 8'd1);
    step();
    bus.we_m = 0;
    #2 chk("fwd_w", 8'(bus.fwd_a_sel), 8'd2);
    step();

    // Index 0 never forwards or stalls.
    clear_in();
    bus.we_m = 1; bus.rd_m = 0; bus.rs2_e = 0;
    bus.is_load_e = 1; bus.we_e = 1; bus.rd_e = 0; bus.re1_d = 1; bus.rs1_d = 0;
    #2 chk("fwd_b_zero", 8'(bus.fwd_b_sel), 8'd0);
    chk("zero_nostall", 8'(bus.stall_f), 8'd0);
    step();

    // Load-use: stalls for exactly LSC cycles.
    clear_in(); set_load_use();
    #2 chk("lu_c0", 8'(bus.stall_f), 8'd1);
    step();
    clear_in();
    #2 chk("lu_c1", 8'(bus.stall_d), 8'd1);
    step();
    #2 chk("lu_c2", 8'(bus.bubble_e), 8'd0);
    step();

    // Redirect during load-use stall; hazard during FLUSH ignored.
    set_load_use();
    step();
    bus.redirect_e = 1;
    #2 chk("rd_kill0", 8'(bus.kill_f), 8'd1);
    chk("rd_nostall", 8'(bus.stall_f), 8'd0);
    step();
    bus.redirect_e = 0;
    #2 chk("rd_kill1", 8'(bus.kill_d), 8'd1);
    chk("flush_lu_ign", 8'(bus.stall_f), 8'd0);
    step();
    clear_in();
    #2 chk("rd_kill2", 8'(bus.kill_f), 8'd0);
    step();

    // Reset mid-LSTALL leaves no residual stall.
    set_load_use();
    step();
    clear_in(); rst = 1;
    step();
    rst = 0;
    #2 chk("rst_abort", 8'(bus.stall_f), 8'd0);
    step();

`ifdef HAZARD_MULDIV_EN
    clear_in(); bus.md_start_e = 1;
    step();
    bus.md_start_e = 0;
    step(); step(); step();
    bus.md_done = 1;
    #2 chk("md_c4", 8'(bus.stall_f), 8'd1);
    step();
    bus.md_done = 0;
    #2 chk("md_c5", 8'(bus.stall_f), 8'd0);
    step();
    bus.md_start_e = 1;
    step();
    bus.md_start_e = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    #2 chk("md_rst", 8'(bus.stall_f), 8'd0);
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 49) == 0);
      bus.redirect_e = ($urandom_range(0, 9) == 0);
      bus.is_load_e  = ($urandom_range(0, 2) == 0);
      bus.we_e       = $urandom_range(0, 1) != 0;
      bus.we_m       = $urandom_range(0, 1) != 0;
      bus.we_w       = $urandom_range(0, 1) != 0;
      bus.re1_d      = $urandom_range(0, 1) != 0;
      bus.re2_d      = $urandom_range(0, 1) != 0;
      bus.rs1_d      = AW'($urandom_range(0, 3));
      bus.rs2_d      = AW'($urandom_range(0, 3));
      bus.rs1_e      = AW'($urandom_range(0, 3));
      bus.rs2_e      = AW'($urandom_range(0, 3));
      bus.rd_e       = AW'($urandom_range(0, 3));
      bus.rd_m       = AW'($urandom_range(0, 3));
      bus.rd_w       = AW'($urandom_range(0, 3));
      bus.md_start_e = ($urandom_range(0, 7) == 0);
      bus.md_done    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
